// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned NCH_DEF   = 4;
  localparam int unsigned CNT_W_DEF = 16;

  // Auto 50% high count: ceil((div+1)/2), high phase first. Wide enough for div = 2^32-1.
  function automatic logic [32:0] auto_hi(input logic [31:0] div);
    logic [32:0] w_sum;
    w_sum   = {1'b0, div} + 33'd2;
    auto_hi = w_sum >> 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: shadow config, pending flag, counter, active period/high count, registered outputs.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_f,
  input  logic [CNT_W-1:0] duty,
  input  logic             load,
  input  logic             sync,
  output logic             d_clock,
  output logic             tick
);

  // High count needs one extra bit: period can reach 2^CNT_W.
  localparam int unsigned HI_W = CNT_W + 1;

  logic [CNT_W-1:0] r_sh_div;
  logic [CNT_W-1:0] r_sh_duty;
  logic             r_pend;
  logic [CNT_W-1:0] r_act_div;
  logic [HI_W-1:0]  r_act_hi;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_d_clock;
  logic             r_tick;

  logic             w_wrap;
  logic             w_bound;
  logic [CNT_W-1:0] w_div_nxt;
  logic [HI_W-1:0]  w_hi_nxt;
  logic             w_pend_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // High-cycle count for a {div, duty} pair: auto 50% when duty is 0, else duty clipped to the period.
  function automatic logic [HI_W-1:0] calc_hi(input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] dt);
    logic [HI_W-1:0] w_per;
    logic [HI_W-1:0] w_dt;
    w_per = HI_W'(d) + HI_W'(1);
    w_dt  = HI_W'(dt);
    if (dt == '0)        calc_hi = HI_W'(auto_hi(32'(d)));
    else if (w_dt > w_per) calc_hi = w_per;
    else                 calc_hi = w_dt;
  endfunction

  // A boundary is the last cycle of a period, a disabled or just-restarted channel, or a global sync.
  assign w_wrap  = (r_cnt == r_act_div);
  assign w_bound = w_wrap || !en || sync || !r_run;

  // Next active config (new load wins at a boundary), pending flag and counter.
  always_comb begin
    w_div_nxt  = r_act_div;
    w_hi_nxt   = r_act_hi;
    w_pend_nxt = r_pend;
    w_cnt_nxt  = r_cnt;
    if (load && w_bound) begin
      w_div_nxt  = div_f;
      w_hi_nxt   = calc_hi(div_f, duty);
      w_pend_nxt = 1'b0;
    end else if (load) begin
      w_pend_nxt = 1'b1;
    end else if (r_pend && w_bound) begin
      w_div_nxt  = r_sh_div;
      w_hi_nxt   = calc_hi(r_sh_div, r_sh_duty);
      w_pend_nxt = 1'b0;
    end
    if (!en) begin
      w_cnt_nxt = '0;
    end else if (!r_run || sync || w_wrap) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Shadow registers capture every load strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_div  <= '0;
      r_sh_duty <= '0;
    end else if (load) begin
      r_sh_div  <= div_f;
      r_sh_duty <= duty;
    end
  end

  // Active config, counter and outputs; outputs use next-state values so they line up with the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend    <= 1'b0;
      r_act_div <= '0;
      r_act_hi  <= '0;
      r_cnt     <= '0;
      r_run     <= 1'b0;
      r_d_clock <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_pend    <= w_pend_nxt;
      r_act_div <= w_div_nxt;
      r_act_hi  <= w_hi_nxt;
      r_cnt     <= w_cnt_nxt;
      r_run     <= en;
      r_d_clock <= en && ({1'b0, w_cnt_nxt} < w_hi_nxt);
      r_tick    <= en && (w_cnt_nxt == w_div_nxt);
    end
  end

  assign d_clock = r_d_clock;
  assign tick    = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider: one clk_div_ch per channel, sharing clk, rst and sync.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH   = NCH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH*CNT_W-1:0] div_f,
  input  logic [NCH*CNT_W-1:0] duty,
  input  logic [NCH-1:0]       load,
  input  logic                 sync,
  output logic [NCH-1:0]       d_clock,
  output logic [NCH-1:0]       tick
);

  // One independent channel per slice of the packed config buses.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .div_f   (div_f[g*CNT_W +: CNT_W]),
      .duty    (duty[g*CNT_W +: CNT_W]),
      .load    (load[g]),
      .sync    (sync),
      .d_clock (d_clock[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed patterns plus random traffic against a period/phase reference model.
module tb_clk_div_multi;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       en;
  logic [NCH*CNT_W-1:0] div_f;
  logic [NCH*CNT_W-1:0] duty;
  logic [NCH-1:0]       load;
  logic                 sync;
  logic [NCH-1:0]       d_clock;
  logic [NCH-1:0]       tick;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NCH   (NCH),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_f   (div_f),
    .duty    (duty),
    .load    (load),
    .sync    (sync),
    .d_clock (d_clock),
    .tick    (tick)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: period length, high length, phase within period, shadow config, pending flag.
  int m_per   [NCH];
  int m_hi    [NCH];
  int m_phase [NCH];
  int m_sh_div[NCH];
  int m_sh_dty[NCH];
  bit m_pend  [NCH];
  bit m_run   [NCH];
  bit exp_d   [NCH];
  bit exp_t   [NCH];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_hi(input int dv, input int dt);
    int p;
    p = dv + 1;
    if (dt == 0) return (p + 1) / 2;
    return (dt < p) ? dt : p;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_per[c]    = 1;
      m_hi[c]     = 0;
      m_phase[c]  = 0;
      m_sh_div[c] = 0;
      m_sh_dty[c] = 0;
      m_pend[c]   = 1'b0;
      m_run[c]    = 1'b0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      int d_in;
      int t_in;
      bit last;
      bit bnd;
      d_in = int'(div_f[c*CNT_W +: CNT_W]);
      t_in = int'(duty[c*CNT_W +: CNT_W]);
      last = (m_phase[c] == m_per[c] - 1);
      bnd  = !en[c] || !m_run[c] || sync || last;
      if (load[c]) begin
        m_sh_div[c] = d_in;
        m_sh_dty[c] = t_in;
        if (bnd) begin
          m_per[c]  = d_in + 1;
          m_hi[c]   = ref_hi(d_in, t_in);
          m_pend[c] = 1'b0;
        end else begin
          m_pend[c] = 1'b1;
        end
      end else if (m_pend[c] && bnd) begin
        m_per[c]  = m_sh_div[c] + 1;
        m_hi[c]   = ref_hi(m_sh_div[c], m_sh_dty[c]);
        m_pend[c] = 1'b0;
      end
      if (!en[c] || !m_run[c] || sync || last) m_phase[c] = 0;
      else                                      m_phase[c] = m_phase[c] + 1;
      m_run[c] = en[c];
      exp_d[c] = en[c] && (m_phase[c] < m_hi[c]);
      exp_t[c] = en[c] && (m_phase[c] == m_per[c] - 1);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      check_eq($sformatf("model_d%0d", c), int'(d_clock[c]), int'(exp_d[c]));
      check_eq($sformatf("model_t%0d", c), int'(tick[c]), int'(exp_t[c]));
    end
  endtask

  task automatic expect_out(input string tag, input int c, input int d, input int t);
    check_eq({tag, "_d"}, int'(d_clock[c]), d);
    check_eq({tag, "_t"}, int'(tick[c]), t);
  endtask

  task automatic set_cfg(input int c, input int dv, input int dt);
    div_f[c*CNT_W +: CNT_W] = CNT_W'(dv);
    duty[c*CNT_W +: CNT_W]  = CNT_W'(dt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int c = 0; c < NCH; c++) expect_out("rst", c, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    en    = '0;
    div_f = '0;
    duty  = '0;
    load  = '0;
    sync  = 1'b0;
    #2;
    do_reset();
    repeat (2) cycle();

    // ch0 div=3 auto duty: 1,1,0,0 with tick at the last phase
    set_cfg(0, 3, 0); load = 4'b0001; cycle();
    load = '0; en = 4'b0001; cycle();
    for (int i = 0; i < 8; i++) begin
      expect_out("t2", 0, int'(i % 4 < 2), int'(i % 4 == 3));
      cycle();
    end

    // ch1 auto 5, ch2 duty 1 of 5, ch3 duty above period
    en = '0;
    set_cfg(1, 4, 0); set_cfg(2, 4, 1); set_cfg(3, 2, 7);
    load = 4'b1110; cycle();
    load = '0; en = 4'b1110; cycle();
    for (int i = 0; i < 15; i++) begin
      expect_out("t3c1", 1, int'(i % 5 < 3), int'(i % 5 == 4));
      expect_out("t3c2", 2, int'(i % 5 == 0), int'(i % 5 == 4));
      expect_out("t3c3", 3, 1, int'(i % 3 == 2));
      cycle();
    end

    // Mid-run reset, then stay idle with en low
    do_reset();
    en = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      for (int c = 0; c < NCH; c++) expect_out("t1", c, 0, 0);
    end

    // Reload mid-period waits for the wrap; reload at the wrap takes effect next cycle
    set_cfg(0, 3, 0); load = 4'b0001; cycle();
    load = '0; en = 4'b0001; cycle();
    expect_out("t4c0", 0, 1, 0); cycle();
    expect_out("t4c1", 0, 1, 0);
    set_cfg(0, 1, 0); load = 4'b0001; cycle();
    load = '0;
    expect_out("t4c2", 0, 0, 0); cycle();
    expect_out("t4c3", 0, 0, 1); cycle();
    for (int i = 0; i < 4; i++) begin
      expect_out("t4p2", 0, int'(i % 2 == 0), int'(i % 2 == 1));
      if (i == 3) begin
        set_cfg(0, 3, 0);
        load = 4'b0001;
      end
      cycle();
      load = '0;
    end
    for (int i = 0; i < 8; i++) begin
      expect_out("t4p4", 0, int'(i % 4 < 2), int'(i % 4 == 3));
      cycle();
    end

    // Two channels out of phase are realigned by sync
    en = '0;
    set_cfg(0, 5, 0); set_cfg(1, 7, 0);
    load = 4'b0011; cycle();
    load = '0; en = 4'b0001;
    repeat (3) cycle();
    en = 4'b0011;
    repeat (5) cycle();
    sync = 1'b1; cycle();
    sync = 1'b0;
    expect_out("t5c0", 0, 1, 0);
    expect_out("t5c1", 1, 1, 0);
    for (int i = 1; i < 25; i++) begin
      cycle();
      if (i == 24) begin
        expect_out("t5r0", 0, 1, 0);
        expect_out("t5r1", 1, 1, 0);
      end
    end

    // Enable drop mid-period, restart at phase 0; then div=0 auto gives constant high and tick
    en = '0;
    set_cfg(0, 5, 0); load = 4'b0001; cycle();
    load = '0; en = 4'b0001;
    repeat (3) cycle();
    en = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      expect_out("t6off", 0, 0, 0);
    end
    en = 4'b0001; cycle();
    expect_out("t6on", 0, 1, 0);
    en = '0;
    set_cfg(0, 0, 0); load = 4'b0001; cycle();
    load = '0; en = 4'b0001; cycle();
    for (int i = 0; i < 5; i++) begin
      expect_out("t6p1", 0, 1, 1);
      cycle();
    end

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        load = '0;
        if ($urandom_range(0, 7) == 0) en = NCH'($urandom);
        if ($urandom_range(0, 5) == 0) begin
          int c;
          c = int'($urandom_range(0, NCH - 1));
          set_cfg(c, int'($urandom_range(0, 9)),
                  ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12)));
          load[c] = 1'b1;
        end
        sync = ($urandom_range(0, 24) == 0);
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
